// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver, the transmitter and the
// receive FIFO.
//   UART_DATA_W : width of one UART character
//   uart_byte_t : one UART character
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_mem
// DEPTH x 8 storage array for the receive FIFO. One synchronous write port and
// one asynchronous read port. Kept in its own module so it can later be
// swapped for an SRAM macro without touching the FIFO control logic.
// Ports:
//   clk_i     : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : read data (combinational from rd_addr_i)
// ---------------------------------------------------------------------------
module uart_rx_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [PTR_W-1:0] wr_addr_i,
   input  uart_byte_t       wr_data_i,
   input  logic [PTR_W-1:0] rd_addr_i,
   output uart_byte_t       rd_data_o
);

   uart_byte_t mem_q [DEPTH];

   // Storage carries no reset; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer sitting directly behind the UART receiver. Each
// one-cycle byte strobe is captured into a synchronous FIFO; the host drains
// it through a first-word-fall-through valid/ready interface. A byte that
// arrives while the buffer is full (and nothing is popped that cycle) is
// dropped and latches the sticky overflow flag.
//
// Optional build macro: UART_RX_FIFO_TIMEOUT_EN
//   Adds rx_timeout, which asserts after TIMEOUT_CYCLES idle clocks with data
//   still buffered (no push, no pop).
//
// Ports:
//   clk        : clock
//   rst        : asynchronous active-low reset
//   wr_en      : byte strobe from the receiver
//   wr_data    : received byte, sampled when wr_en = 1
//   rd_valid   : head entry available
//   rd_ready   : consumer accepts head entry
//   rd_data    : head byte (fall-through)
//   level      : occupancy 0..DEPTH
//   full       : level == DEPTH
//   empty      : level == 0
//   overflow   : sticky, a byte was dropped
//   ovf_clr    : one-cycle clear of overflow
//   rx_timeout : idle-with-data indication (optional build only)
// ---------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  uart_byte_t       wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output uart_byte_t       rd_data,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty,
   output logic             overflow,
`ifdef UART_RX_FIFO_TIMEOUT_EN
   output logic             rx_timeout,
`endif
   input  logic             ovf_clr
);

   // Elaboration-time parameter guards.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("uart_rx_fifo: TIMEOUT_CYCLES must be >= 1");
   end

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             ovf_q, ovf_d;
   uart_byte_t       hold_q, hold_d;
   uart_byte_t       mem_rdata;
   logic             push, pop;

   assign pop  = !empty_q && rd_ready;
   // A pop frees the slot in the same cycle, so a full FIFO can still accept.
   assign push = wr_en && (!full_q || pop);

   uart_rx_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i     (clk),
      .wr_en_i   (push),
      .wr_addr_i (wptr_q),
      .wr_data_i (wr_data),
      .rd_addr_i (rptr_q),
      .rd_data_o (mem_rdata)
   );

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      hold_d  = hold_q;
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      full_d  = (level_d == LVL_W'(DEPTH));
      empty_d = (level_d == '0);
      if (push) begin
         wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_W'(1);
         // Remember the byte just consumed so rd_data holds it once empty.
         hold_d = mem_rdata;
      end
      // Setting dominates a simultaneous clear.
      if (wr_en && full_q && !pop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         hold_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
         hold_q  <= hold_d;
      end
   end

   assign rd_valid = !empty_q;
   assign rd_data  = empty_q ? hold_q : mem_rdata;
   assign level    = level_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign overflow = ovf_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
   logic [31:0] idle_q, idle_d;
   logic        tmo_q, tmo_d;

   always_comb begin
      if (push || pop || empty_q) begin
         idle_d = '0;
      end else if (idle_q != 32'(TIMEOUT_CYCLES)) begin
         idle_d = idle_q + 32'd1;
      end else begin
         idle_d = idle_q;
      end
      tmo_d = (idle_d == 32'(TIMEOUT_CYCLES)) && !empty_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         idle_q <= idle_d;
         tmo_q  <= tmo_d;
      end
   end

   assign rx_timeout = tmo_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             wr_en = 1'b0;
   uart_byte_t       wr_data = '0;
   logic             rd_valid;
   logic             rd_ready = 1'b0;
   uart_byte_t       rd_data;
   logic [LVL_W-1:0] level;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
   logic             rx_timeout;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DEPTH          (DEPTH),
`ifdef UART_RX_FIFO_TIMEOUT_EN
      .TIMEOUT_CYCLES (8)
`else
      .TIMEOUT_CYCLES (1024)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .level      (level),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
`ifdef UART_RX_FIFO_TIMEOUT_EN
      .rx_timeout (rx_timeout),
`endif
      .ovf_clr    (ovf_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic pop_one();
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
   endtask

   initial begin
      // ---- reset state ----
      step(3);
      check("rst_valid", 32'(rd_valid), 0);
      check("rst_level", 32'(level), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_data", 32'(rd_data), 32'h00);
      rst = 1'b1;
      step(2);

      // ---- test 1: two spaced bytes ----
      write_byte(8'hA5);
      check("t1_lat_valid", 32'(rd_valid), 1);
      check("t1_lat_data", 32'(rd_data), 32'hA5);
      step(10);
      write_byte(8'h3C);
      step(10);
      check("t1_level", 32'(level), 2);
      check("t1_data0", 32'(rd_data), 32'hA5);
      check("t1_valid", 32'(rd_valid), 1);
      pop_one();
      check("t1_data1", 32'(rd_data), 32'h3C);
      check("t1_level1", 32'(level), 1);
      pop_one();
      check("t1_empty", 32'(empty), 1);
      check("t1_level0", 32'(level), 0);
      check("t1_hold", 32'(rd_data), 32'h3C);
      // rd_ready while empty does nothing
      pop_one();
      check("t1_rdy_empty", 32'(level), 0);

      // ---- test 2: fill, overflow, drain, clear ----
      for (int i = 0; i < 16; i++) write_byte(8'(i));
      check("t2_full", 32'(full), 1);
      check("t2_level", 32'(level), 16);
      check("t2_ovf_pre", 32'(overflow), 0);
      write_byte(8'h10);
      check("t2_ovf", 32'(overflow), 1);
      check("t2_level_ovf", 32'(level), 16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t2_drain%0d", i), 32'(rd_data), 32'(i));
         pop_one();
      end
      check("t2_empty", 32'(empty), 1);
      check("t2_ovf_hold", 32'(overflow), 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t2_ovf_clr", 32'(overflow), 0);

      // ---- test 3: push + pop on a full FIFO ----
      for (int i = 0; i < 16; i++) write_byte(8'(8'h20 + i));
      check("t3_full", 32'(full), 1);
      wr_en = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
      step();
      wr_en = 1'b0; rd_ready = 1'b0;
      check("t3_no_ovf", 32'(overflow), 0);
      check("t3_level", 32'(level), 16);
      check("t3_full2", 32'(full), 1);
      for (int i = 1; i < 16; i++) begin
         check($sformatf("t3_drain%0d", i), 32'(rd_data), 32'(8'h20 + i));
         pop_one();
      end
      check("t3_last", 32'(rd_data), 32'h77);
      pop_one();
      check("t3_empty", 32'(empty), 1);

      // ---- test 4: streaming across pointer wrap ----
      for (int i = 0; i < 40; i++) begin
         write_byte(8'(8'h80 + i));
         check($sformatf("t4_lvl%0d", i), 32'(level), 1);
         check($sformatf("t4_data%0d", i), 32'(rd_data), 32'(8'h80 + i));
         pop_one();
         check($sformatf("t4_empty%0d", i), 32'(empty), 1);
      end

      // ---- test 5: asynchronous mid-stream reset ----
      for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i));
      write_byte(8'hEE);
      for (int i = 0; i < 11; i++) pop_one();
      check("t5_level5", 32'(level), 5);
      check("t5_ovf1", 32'(overflow), 1);
      #2;
      rst = 1'b0;
      #1;
      check("t5_async_level", 32'(level), 0);
      check("t5_async_empty", 32'(empty), 1);
      check("t5_async_ovf", 32'(overflow), 0);
      check("t5_async_valid", 32'(rd_valid), 0);
      check("t5_async_data", 32'(rd_data), 32'h00);
      step(2);
      rst = 1'b1;
      step();
      write_byte(8'h11);
      check("t5_rd11", 32'(rd_data), 32'h11);
      check("t5_lvl1", 32'(level), 1);
      pop_one();
      check("t5_empty", 32'(empty), 1);

`ifdef UART_RX_FIFO_TIMEOUT_EN
      // ---- test 6: receive timeout ----
      check("t6_tmo_init", 32'(rx_timeout), 0);
      write_byte(8'h5A);
      step(7);
      check("t6_tmo7", 32'(rx_timeout), 0);
      step();
      check("t6_tmo8", 32'(rx_timeout), 1);
      step(3);
      check("t6_tmo_sat", 32'(rx_timeout), 1);
      pop_one();
      check("t6_tmo_pop", 32'(rx_timeout), 0);
      step(20);
      check("t6_tmo_empty", 32'(rx_timeout), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net in case the stimulus ever stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver.
- Captures each byte the receiver delivers on its one-cycle ready pulse into a synchronous FIFO.
- Presents buffered bytes to the host/bus side through a valid/ready handshake.
- Flags overflow when the receiver delivers a byte into a full buffer, so the slow consumer never silently misses data.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 1024, idle clocks before the receive timeout asserts; used only with the optional feature; minimum 1.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  asynchronous, active-low reset; the block is in reset while rst = 0.
- wr_en  input  1  one-cycle byte strobe from the receiver's rdy output.
- wr_data  input  8  received byte from the receiver's data_out; sampled only when wr_en = 1.
- rd_valid  output  1  head entry available on rd_data.
- rd_ready  input  1  consumer accepts the head entry.
- rd_data  output  8  head byte, first-word-fall-through.
- level  output  $clog2(DEPTH+1)  current occupancy, range 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  sticky: a byte was dropped.
- ovf_clr  input  1  one-cycle clear for overflow.

Behaviour:
Reset:
- Asynchronous on rst falling; all state is held while rst = 0.
- Outputs during reset: rd_valid=0, level=0, empty=1, full=0, overflow=0, rd_data=8'h00.
- Storage contents are don't-care after reset.
- A mid-operation reset discards all buffered bytes and the overflow flag.

Definitions:
- push = wr_en && (!full || pop).
- pop = rd_valid && rd_ready.
- rd_valid = !empty.

Write side:
- On push, store wr_data at the write pointer and advance it; the pointer wraps modulo DEPTH.
- The byte is visible on rd_data the cycle after the push edge (1-cycle write-to-read latency).

Read side:
- rd_data always shows the entry at the read pointer while rd_valid = 1.
- On pop, advance the read pointer (wraps modulo DEPTH); the next entry appears the following cycle.
- When empty, rd_data holds its last value and is don't-care for the consumer.
- rd_ready asserted while empty has no effect.

Simultaneous events:
- Push and pop in the same cycle: level unchanged. This is legal when full (the pop frees the slot) and when empty is false.
- When empty, a push and rd_ready in the same cycle perform only the push; there is no combinational bypass.

Level update:
- level' = level + push - pop.
- full and empty are registered and consistent with level every cycle.
- Pointers use $clog2(DEPTH) bits plus an occupancy counter; no pointer-compare ambiguity.

Overflow:
- wr_en && full && !pop: the byte is dropped and overflow sets to 1 on the next edge.
- overflow holds until ovf_clr = 1.
- A set condition in the same cycle as ovf_clr dominates: overflow stays 1.
- FIFO contents are never corrupted by a dropped byte.

No internal state machine beyond the pointers and counter; all outputs are registered except rd_data (memory read at the read pointer).

Optional Feature:
UART_RX_FIFO_TIMEOUT_EN
- Enabled:
  - Adds output rx_timeout (1 bit, reset 0) and a 32-bit idle counter.
  - The counter clears on any push, any pop, or while empty; otherwise it increments, saturating at TIMEOUT_CYCLES.
  - rx_timeout = 1 once the counter equals TIMEOUT_CYCLES and the FIFO is non-empty.
  - rx_timeout drops in the cycle after the next push, pop, or reset.
  - Intended for interrupting on short messages that never reach a threshold.
- Disabled: neither the port nor the counter exists; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package uart_pkg:
  - UART_DATA_W = 8.
  - typedef uart_byte_t (logic [UART_DATA_W-1:0]).
  - Shared by receiver, transmitter and this FIFO.
- Sub-module uart_rx_fifo_mem:
  - DEPTH x 8 register array.
  - One synchronous write port, one asynchronous read port indexed by the read pointer.
  - Keeps storage separable for later SRAM substitution.
- Pointer, counter, overflow and timeout logic stay in uart_rx_fifo.

Test Plan:
1. Reset then write 8'hA5, 8'h3C (one pulse each, gaps of 10 clocks), rd_ready=0 -> level=2, rd_data=8'hA5, rd_valid=1; pop twice -> rd_data=8'h3C then empty=1, level=0.
2. DEPTH=16: write bytes 0x00..0x0F -> full=1, level=16; write 0x10 -> overflow=1, byte dropped; drain -> reads 0x00..0x0F in order; pulse ovf_clr -> overflow=0.
3. Full FIFO; wr_en with 8'h77 and rd_ready=1 in the same cycle -> no overflow, level stays 16; 8'h77 is read last.
4. Wrap-around: 40 bytes streamed with the consumer popping 1 cycle after each write -> order preserved across pointer wrap; level never exceeds 1.
5. Assert rst=0 with level=5 and overflow=1, mid-stream -> level=0, empty=1, overflow=0 immediately (asynchronous); after release, the first write of 8'h11 is read back as 8'h11.
6. With UART_RX_FIFO_TIMEOUT_EN, TIMEOUT_CYCLES=8: write 1 byte and idle -> rx_timeout=1 after 8 clocks; pop -> rx_timeout=0 next cycle; empty idle of 20 clocks -> rx_timeout stays 0.
